vec_cond_unit: RTL and testbench

- Per-lane condition/predication unit for the vector ASIP execute stage. Parametrised successor of the scalar condition logic.
- Holds registered Z/N/C/V flags per lane and evaluates a 4-bit condition code per lane. It gates register and memory writes per lane and resolves branches.
- Adds a hardware loop counter and a post-branch flush window.
- Sits between the vector ALU flag outputs, the control decoder, and the fetch PC mux.

---
 rtl/vec_cond_unit.sv | 133 +++++++++++++
 tb/tb_vec_cond_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_cond_unit.sv
// Per-lane condition/predication unit for the vector execute stage.
// Keeps registered lane flags, gates register/memory writes, resolves branches, loop counter and flush window.
module vec_cond_unit #(
  parameter int LANES     = 4,
  parameter int CNT_W     = 8,
  parameter int FLUSH_CYC = 2,
  parameter int BR_MODE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag_we,
  input  logic [LANES-1:0] lane_mask,
  input  logic [LANES-1:0] alu_zero,
  input  logic [LANES-1:0] alu_neg,
  input  logic [LANES-1:0] alu_carry,
  input  logic [LANES-1:0] alu_ovf,
  input  logic             pcs,
  input  logic             reg_w,
  input  logic             mem_w,
  input  logic [3:0]       cond,
  input  logic             loop_load,
  input  logic [CNT_W-1:0] loop_init,
  output logic             pc_src,
  output logic [LANES-1:0] reg_write,
  output logic [LANES-1:0] mem_write,
  output logic             post_alu_mux_sel,
  output logic             flush,
  output logic [CNT_W-1:0] loop_count
);

  // A zero-length flush counter is not legal, so keep one bit that simply stays 0.
  localparam int FC_W = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

  localparam logic [3:0] C_AL   = 4'd0;
  localparam logic [3:0] C_EQ   = 4'd1;
  localparam logic [3:0] C_NE   = 4'd2;
  localparam logic [3:0] C_LT   = 4'd3;
  localparam logic [3:0] C_GE   = 4'd4;
  localparam logic [3:0] C_GT   = 4'd5;
  localparam logic [3:0] C_LE   = 4'd6;
  localparam logic [3:0] C_CS   = 4'd7;
  localparam logic [3:0] C_CC   = 4'd8;
  localparam logic [3:0] C_LOOP = 4'd9;

  logic [LANES-1:0] z_q, n_q, c_q, v_q;
  logic [FC_W-1:0]  fc_q;
  logic [CNT_W-1:0] loop_q;

  logic [LANES-1:0] cond_true;
  logic             flush_i;
  logic             loop_nz;
  logic             br_true;
  logic             pc_src_i;
  logic             loop_dec;

  assign flush_i = (fc_q != '0);
  assign loop_nz = (loop_q != '0);

  // Conditions always look at registered flags, never at this cycle's ALU results.
  always_comb begin
    cond_true = '0;
    for (int i = 0; i < LANES; i++) begin
      case (cond)
        C_AL:    cond_true[i] = 1'b1;
        C_EQ:    cond_true[i] = z_q[i];
        C_NE:    cond_true[i] = ~z_q[i];
        C_LT:    cond_true[i] = n_q[i] ^ v_q[i];
        C_GE:    cond_true[i] = ~(n_q[i] ^ v_q[i]);
        C_GT:    cond_true[i] = ~z_q[i] & ~(n_q[i] ^ v_q[i]);
        C_LE:    cond_true[i] = z_q[i] | (n_q[i] ^ v_q[i]);
        C_CS:    cond_true[i] = c_q[i];
        C_CC:    cond_true[i] = ~c_q[i];
        C_LOOP:  cond_true[i] = loop_nz;
        default: cond_true[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    br_true = 1'b0;
    if (BR_MODE == 1) begin
      br_true = |(cond_true & lane_mask);
    end else if (BR_MODE == 2) begin
      br_true = (lane_mask != '0) & (&(cond_true | ~lane_mask));
    end else begin
      br_true = cond_true[0];
    end
  end

  assign pc_src_i = reset & pcs & br_true & ~flush_i;
  assign loop_dec = pcs & (cond == C_LOOP) & ~flush_i & loop_nz;

  assign pc_src           = pc_src_i;
  assign post_alu_mux_sel = pc_src_i & (cond != C_AL);
  assign flush            = reset & flush_i;
  assign loop_count       = loop_q;
  assign reg_write        = {LANES{reset & reg_w & ~flush_i}} & lane_mask & cond_true;
  assign mem_write        = {LANES{reset & mem_w & ~flush_i}} & lane_mask & cond_true;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z_q    <= '0;
      n_q    <= '0;
      c_q    <= '0;
      v_q    <= '0;
      fc_q   <= '0;
      loop_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (flag_we && lane_mask[i] && !flush_i) begin
          z_q[i] <= alu_zero[i];
          n_q[i] <= alu_neg[i];
          c_q[i] <= alu_carry[i];
          v_q[i] <= alu_ovf[i];
        end
      end

      // A load wins over a same-cycle LOOP decrement; the branch itself still saw the old count.
      if (loop_load) begin
        loop_q <= loop_init;
      end else if (loop_dec) begin
        loop_q <= loop_q - CNT_W'(1);
      end

      if (pc_src_i) begin
        fc_q <= FC_W'(FLUSH_CYC);
      end else if (flush_i) begin
        fc_q <= fc_q - FC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vec_cond_unit.sv
// Directed bench for vec_cond_unit: four instances share stimulus and cover
// BR_MODE 0/1/2 with a 2-cycle flush window and BR_MODE 0 with flush disabled.
module tb_vec_cond_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       flag_we;
  logic [3:0] lane_mask, alu_zero, alu_neg, alu_carry, alu_ovf;
  logic       pcs, reg_w, mem_w, loop_load;
  logic [3:0] cond;
  logic [7:0] loop_init;

  logic       pc_src [4];
  logic [3:0] reg_write [4];
  logic [3:0] mem_write [4];
  logic       post_sel [4];
  logic       flush [4];
  logic [7:0] loop_count [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vec_cond_unit #(.LANES(4), .CNT_W(8), .FLUSH_CYC(2), .BR_MODE(0)) u0 (
    .clk(clk), .reset(reset), .flag_we(flag_we), .lane_mask(lane_mask),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .cond(cond),
    .loop_load(loop_load), .loop_init(loop_init),
    .pc_src(pc_src[0]), .reg_write(reg_write[0]), .mem_write(mem_write[0]),
    .post_alu_mux_sel(post_sel[0]), .flush(flush[0]), .loop_count(loop_count[0]));

  vec_cond_unit #(.LANES(4), .CNT_W(8), .FLUSH_CYC(2), .BR_MODE(1)) u1 (
    .clk(clk), .reset(reset), .flag_we(flag_we), .lane_mask(lane_mask),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .cond(cond),
    .loop_load(loop_load), .loop_init(loop_init),
    .pc_src(pc_src[1]), .reg_write(reg_write[1]), .mem_write(mem_write[1]),
    .post_alu_mux_sel(post_sel[1]), .flush(flush[1]), .loop_count(loop_count[1]));

  vec_cond_unit #(.LANES(4), .CNT_W(8), .FLUSH_CYC(2), .BR_MODE(2)) u2 (
    .clk(clk), .reset(reset), .flag_we(flag_we), .lane_mask(lane_mask),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .cond(cond),
    .loop_load(loop_load), .loop_init(loop_init),
    .pc_src(pc_src[2]), .reg_write(reg_write[2]), .mem_write(mem_write[2]),
    .post_alu_mux_sel(post_sel[2]), .flush(flush[2]), .loop_count(loop_count[2]));

  vec_cond_unit #(.LANES(4), .CNT_W(8), .FLUSH_CYC(0), .BR_MODE(0)) u3 (
    .clk(clk), .reset(reset), .flag_we(flag_we), .lane_mask(lane_mask),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .cond(cond),
    .loop_load(loop_load), .loop_init(loop_init),
    .pc_src(pc_src[3]), .reg_write(reg_write[3]), .mem_write(mem_write[3]),
    .post_alu_mux_sel(post_sel[3]), .flush(flush[3]), .loop_count(loop_count[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flag_we = 1'b0; pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; loop_load = 1'b0;
    cond = 4'd0; lane_mask = 4'hF;
  endtask

  initial begin
    reset = 1'b0; flag_we = 1'b0; lane_mask = 4'hF; alu_zero = '0; alu_neg = '0;
    alu_carry = '0; alu_ovf = '0; pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0;
    cond = 4'd0; loop_load = 1'b0; loop_init = '0;

    // reset holds outputs low even with an AL write request
    reg_w = 1'b1;
    tick(); tick();
    #2;
    check("rst_reg_write", 32'(reg_write[0]), 0);
    check("rst_loop_count", 32'(loop_count[0]), 0);
    check("rst_flush", 32'(flush[0]), 0);
    reset = 1'b1;
    #2;
    check("rel_reg_write", 32'(reg_write[0]), 'hF);

    // per-lane predication
    tick(); idle();
    flag_we = 1'b1; alu_zero = 4'b0101;
    tick(); idle();
    cond = 4'd1; reg_w = 1'b1;
    #2;
    check("pred_eq_reg", 32'(reg_write[0]), 'b0101);
    reg_w = 1'b0; mem_w = 1'b1; cond = 4'd2;
    #2;
    check("pred_ne_mem", 32'(mem_write[0]), 'b1010);
    check("pred_ne_reg_off", 32'(reg_write[0]), 0);

    // conditions use flags from before this cycle's update
    tick(); idle();
    flag_we = 1'b1; alu_zero = 4'hF; cond = 4'd1; reg_w = 1'b1;
    #2;
    check("old_flags_used", 32'(reg_write[0]), 'b0101);
    tick(); idle();
    cond = 4'd1; reg_w = 1'b1;
    #2;
    check("new_flags_seen", 32'(reg_write[0]), 'hF);

    // masked flag update touches only lanes 0,1
    tick(); idle();
    flag_we = 1'b1; lane_mask = 4'b0011; alu_zero = 4'h0;
    tick(); idle();
    cond = 4'd1; reg_w = 1'b1;
    #2;
    check("masked_flag_upd", 32'(reg_write[0]), 'b1100);

    // branch reduction with Z = 0010
    tick(); idle();
    flag_we = 1'b1; alu_zero = 4'b0010;
    tick(); idle();
    cond = 4'd1; pcs = 1'b1;
    #2;
    check("br0_pc_src", 32'(pc_src[0]), 0);
    check("br1_pc_src", 32'(pc_src[1]), 1);
    check("br1_post_sel", 32'(post_sel[1]), 1);
    check("br2_full_mask", 32'(pc_src[2]), 0);
    check("br1_no_self_flush", 32'(flush[1]), 0);

    // t+1: u1 flushed, u2 takes with the narrowed mask
    tick();
    lane_mask = 4'b0010; reg_w = 1'b1;
    #2;
    check("br2_pc_src", 32'(pc_src[2]), 1);
    check("fl_t1_flush", 32'(flush[1]), 1);
    check("fl_t1_pc_src", 32'(pc_src[1]), 0);
    check("fl_t1_reg_write", 32'(reg_write[1]), 0);
    check("nofl_reg_write", 32'(reg_write[0]), 'b0010);

    // t+2: flag write suppressed on flushed units
    tick(); idle();
    flag_we = 1'b1; alu_zero = 4'hF;
    #2;
    check("fl_t2_flush", 32'(flush[1]), 1);

    // t+3: u1 window closed, u2 still in its second flush cycle
    tick(); idle();
    cond = 4'd1; reg_w = 1'b1;
    #2;
    check("fl_t3_flush", 32'(flush[1]), 0);
    check("fl_flags_held", 32'(reg_write[1]), 'b0010);
    check("nofl_flags_upd", 32'(reg_write[0]), 'hF);
    check("br2_fl_second", 32'(flush[2]), 1);
    check("br2_fl_reg_write", 32'(reg_write[2]), 0);
    tick();
    #2;
    check("br2_fl_done", 32'(flush[2]), 0);

    // empty mask: mode 2 never taken, mode 0 looks at lane 0 only
    tick(); idle();
    pcs = 1'b1; lane_mask = 4'h0;
    #2;
    check("br2_empty_mask", 32'(pc_src[2]), 0);
    check("br1_empty_mask", 32'(pc_src[1]), 0);
    check("br0_al_taken", 32'(pc_src[0]), 1);
    check("br0_al_post_sel", 32'(post_sel[0]), 0);
    tick(); idle();
    #2;
    check("fc0_never_flush", 32'(flush[3]), 0);
    tick(); tick(); tick();

    // hardware loop on the flush-free instance
    idle();
    loop_load = 1'b1; loop_init = 8'd3;
    tick(); idle();
    cond = 4'd9; pcs = 1'b1;
    #2;
    check("loop_pc_1", 32'(pc_src[3]), 1);
    check("loop_cnt_3", 32'(loop_count[3]), 3);
    tick(); #2;
    check("loop_pc_2", 32'(pc_src[3]), 1);
    check("loop_cnt_2", 32'(loop_count[3]), 2);
    tick(); #2;
    check("loop_pc_3", 32'(pc_src[3]), 1);
    check("loop_cnt_1", 32'(loop_count[3]), 1);
    tick(); #2;
    check("loop_pc_4", 32'(pc_src[3]), 0);
    check("loop_cnt_0", 32'(loop_count[3]), 0);
    check("loop_no_flush", 32'(flush[3]), 0);
    tick(); #2;
    check("loop_saturate", 32'(loop_count[3]), 0);
    loop_load = 1'b1; loop_init = 8'd1;
    tick();
    loop_init = 8'd5;
    #2;
    check("load_br_old_cnt", 32'(pc_src[3]), 1);
    tick(); idle();
    #2;
    check("load_beats_dec", 32'(loop_count[3]), 5);

    // signed conditions, N=1 V=0
    flag_we = 1'b1; alu_zero = 4'h0; alu_neg = 4'hF; alu_ovf = 4'h0; alu_carry = 4'b0101;
    tick(); idle();
    reg_w = 1'b1;
    cond = 4'd3; #2; check("lt_true", 32'(reg_write[3]), 'hF);
    cond = 4'd4; #2; check("ge_false", 32'(reg_write[3]), 0);
    cond = 4'd5; #2; check("gt_false", 32'(reg_write[3]), 0);
    cond = 4'd6; #2; check("le_true", 32'(reg_write[3]), 'hF);
    cond = 4'd7; #2; check("cs_lanes", 32'(reg_write[3]), 'b0101);
    cond = 4'd8; #2; check("cc_lanes", 32'(reg_write[3]), 'b1010);
    tick(); idle();
    flag_we = 1'b1; alu_neg = 4'hF; alu_ovf = 4'hF;
    tick(); idle();
    reg_w = 1'b1; cond = 4'd5;
    #2;
    check("gt_true_nv", 32'(reg_write[3]), 'hF);
    cond = 4'd12; mem_w = 1'b1; pcs = 1'b1;
    #2;
    check("nv_reg_write", 32'(reg_write[3]), 0);
    check("nv_mem_write", 32'(mem_write[3]), 0);
    check("nv_pc_src", 32'(pc_src[3]), 0);
    check("nv_post_sel", 32'(post_sel[3]), 0);

    // reset in the middle of a flush window
    tick(); idle();
    pcs = 1'b1;
    tick(); idle();
    #2;
    check("mid_flush_set", 32'(flush[1]), 1);
    reg_w = 1'b1;
    reset = 1'b0;
    #2;
    check("rst_clears_flush", 32'(flush[1]), 0);
    check("rst_clears_loop", 32'(loop_count[3]), 0);
    check("rst_gates_write", 32'(reg_write[1]), 0);
    tick();
    reset = 1'b1;
    #2;
    check("post_rst_write", 32'(reg_write[1]), 'hF);
    cond = 4'd7;
    #2;
    check("post_rst_flags", 32'(reg_write[3]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
